// File: rtl/gpio_pkg.sv
// Register map, reset value and byte-lane write merge shared by the GPIO peripheral.
package gpio_pkg;

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_DIR    = 3'd1;
    localparam logic [2:0] OFF_IN     = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN = 3'd3;
    localparam logic [2:0] OFF_RISE   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_TOGGLE = 3'd6;

    localparam logic [31:0] REG_RST_VAL = 32'h0000_0000;

    // Wide enough for a warm-up count of SYNC_STAGES+1 with up to four stages.
    localparam int unsigned WARM_W = 3;

    function automatic logic [31:0] merge_lanes(input logic [31:0]   old_val,
                                                input logic [3:0]    strb,
                                                input logic [31:0]   wbytes,
                                                input int unsigned   width);
        logic [31:0] res;
        logic [31:0] mask;
        res = old_val;
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) res[8*n +: 8] = wbytes[8*n +: 8];
        end
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return res & mask;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for a bus of asynchronous pad inputs.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // NOTE: every stage is reset (it is a flop chain, not a RAM) so no X reaches the edge detector,
    // and non-blocking updates make all stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: per-pin output/direction, synchronised input, edge interrupts with W1C status.
// Define GPIO_TOGGLE_EN to make offset 6 a write-only TOGGLE register.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [4:0]        addr,
    input  logic [3:0]        wr,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    input  logic [7:0]        wdata2,
    input  logic [7:0]        wdata3,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);

    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES + 1);

    logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d, irq_en_q, irq_en_d;
    logic [GPIO_W-1:0] rise_q, rise_d, status_q, status_d, in_d_q, in_d_d;
    logic [GPIO_W-1:0] in_s, edge_hit, w1c;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [31:0]       rdata_q, rdata_d, wbytes;
    logic              irq_q, irq_d;
    logic [2:0]        reg_sel;
    logic              unused_addr_bits;

    gpio_sync #(.WIDTH(GPIO_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_i),
        .dout (in_s)
    );

    assign wbytes           = {wdata3, wdata2, wdata1, wdata0};
    assign reg_sel          = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    function automatic logic [GPIO_W-1:0] lane_write(input logic [GPIO_W-1:0] old_val,
                                                     input logic [3:0]        strb,
                                                     input logic [31:0]       bytes_in);
        logic [31:0] merged;
        merged = merge_lanes(32'(old_val), strb, bytes_in, GPIO_W);
        return merged[GPIO_W-1:0];
    endfunction

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
        out_d    = out_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        rise_d   = rise_q;
        rdata_d  = rdata_q;
        in_d_d   = in_s;
        w1c      = '0;
        edge_hit = '0;
        warm_d   = (warm_q == WARM_MAX) ? warm_q : warm_q + 1'b1;
        irq_d    = |(status_q & irq_en_q);

        // Until the chain and IN_D hold real pin values, a mismatch is reset residue, not an edge.
        if (warm_q == WARM_MAX) begin
            edge_hit = (in_s & ~in_d_q & rise_q) | (~in_s & in_d_q & ~rise_q);
        end

        if (sel) begin
            case (reg_sel)
                OFF_OUT:    rdata_d = 32'(out_q);
                OFF_DIR:    rdata_d = 32'(dir_q);
                OFF_IN:     rdata_d = 32'(in_s);
                OFF_IRQ_EN: rdata_d = 32'(irq_en_q);
                OFF_RISE:   rdata_d = 32'(rise_q);
                OFF_STATUS: rdata_d = 32'(status_q);
                default:    rdata_d = 32'h0;
            endcase

            case (reg_sel)
                OFF_OUT:    out_d    = lane_write(out_q, wr, wbytes);
                OFF_DIR:    dir_d    = lane_write(dir_q, wr, wbytes);
                OFF_IRQ_EN: irq_en_d = lane_write(irq_en_q, wr, wbytes);
                OFF_RISE:   rise_d   = lane_write(rise_q, wr, wbytes);
                OFF_STATUS: w1c      = lane_write('0, wr, wbytes);
`ifdef GPIO_TOGGLE_EN
                OFF_TOGGLE: out_d    = out_q ^ lane_write('0, wr, wbytes);
`endif
                default:    ;
            endcase
        end

        // A new edge overrides a same-cycle clear.
        status_d = (status_q & ~w1c) | edge_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= REG_RST_VAL[GPIO_W-1:0];
            dir_q    <= REG_RST_VAL[GPIO_W-1:0];
            irq_en_q <= REG_RST_VAL[GPIO_W-1:0];
            rise_q   <= REG_RST_VAL[GPIO_W-1:0];
            status_q <= REG_RST_VAL[GPIO_W-1:0];
            in_d_q   <= '0;
            warm_q   <= '0;
            rdata_q  <= REG_RST_VAL;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            irq_en_q <= irq_en_d;
            rise_q   <= rise_d;
            status_q <= status_d;
            in_d_q   <= in_d_d;
            warm_q   <= warm_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign rdata   = rdata_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model of the register rules.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int W = 8;
    localparam int S = 2;
`ifdef GPIO_TOGGLE_EN
    localparam logic [7:0] OUT_AFTER_TGL = 8'h5A;
`else
    localparam logic [7:0] OUT_AFTER_TGL = 8'hA5;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic [4:0]    addr;
    logic [3:0]    wr;
    logic [7:0]    wdata0, wdata1, wdata2, wdata3;
    logic [31:0]   rdata;
    logic [W-1:0]  gpio_i, gpio_o, gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(.GPIO_W(W), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .addr    (addr),
        .wr      (wr),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .wdata2  (wdata2),
        .wdata3  (wdata3),
        .rdata   (rdata),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bus(input logic s, input logic [2:0] reg_idx,
                             input logic [3:0] strb, input logic [31:0] d);
        sel  = s;
        addr = {reg_idx, 2'($urandom_range(0, 3))};
        wr   = strb;
        {wdata3, wdata2, wdata1, wdata0} = d;
    endtask

    task automatic bus_idle();
        sel = 1'b0;
        wr  = 4'b0000;
    endtask

    task automatic bus_write(input logic [2:0] reg_idx, input logic [3:0] strb, input logic [31:0] d);
        drive_bus(1'b1, reg_idx, strb, d);
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] reg_idx, output logic [31:0] d);
        drive_bus(1'b1, reg_idx, 4'b0000, $urandom);
        tick();
        bus_idle();
        d = rdata;
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: registers as plain values, pin history as a queue of sampled pin vectors.
    logic [W-1:0] m_out, m_dir, m_ien, m_rise, m_status;
    logic [31:0]  m_rdata;
    logic         m_irq;
    logic [W-1:0] m_hist[$];
    int           m_edges;

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_ien = '0; m_rise = '0; m_status = '0;
        m_rdata = '0; m_irq = 1'b0; m_edges = 0;
        m_hist = {};
        for (int i = 0; i <= S; i++) m_hist.push_back('0);
    endtask

    task automatic model_step();
        logic [W-1:0] ins, ind, edges, w1c;
        ins   = m_hist[S-1];
        ind   = m_hist[S];
        edges = '0;
        w1c   = '0;
        if (m_edges >= S + 1) begin
            for (int k = 0; k < W; k++)
                if (ins[k] != ind[k] && ins[k] == m_rise[k]) edges[k] = 1'b1;
        end
        m_irq = |(m_status & m_ien);
        if (sel) begin
            case (int'(addr[4:2]))
                0: m_rdata = 32'(m_out);
                1: m_rdata = 32'(m_dir);
                2: m_rdata = 32'(ins);
                3: m_rdata = 32'(m_ien);
                4: m_rdata = 32'(m_rise);
                5: m_rdata = 32'(m_status);
                default: m_rdata = 32'h0;
            endcase
            if (wr[0]) begin
                case (int'(addr[4:2]))
                    0: m_out  = wdata0;
                    1: m_dir  = wdata0;
                    3: m_ien  = wdata0;
                    4: m_rise = wdata0;
                    5: w1c    = wdata0;
`ifdef GPIO_TOGGLE_EN
                    6: m_out  = m_out ^ wdata0;
`endif
                    default: ;
                endcase
            end
        end
        m_status = (m_status & ~w1c) | edges;
        m_hist.push_front(gpio_i);
        void'(m_hist.pop_back());
        m_edges++;
    endtask

    typedef struct {
        logic [2:0]   waddr;
        logic [3:0]   strb;
        logic [31:0]  wdata;
        logic [2:0]   raddr;
        logic [31:0]  exp_rd;
        logic [W-1:0] exp_o;
        logic [W-1:0] exp_oe;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] d;
        int op;

        vecs[0]  = '{OFF_DIR,    4'b0001, 32'h0000_000F, OFF_DIR,    32'h0F, 8'h00, 8'h0F};
        vecs[1]  = '{OFF_DIR,    4'b1110, 32'hFFFF_FF00, OFF_DIR,    32'h0F, 8'h00, 8'h0F};
        vecs[2]  = '{OFF_OUT,    4'b1111, 32'h1234_56A5, OFF_OUT,    32'hA5, 8'hA5, 8'h0F};
        vecs[3]  = '{OFF_OUT,    4'b0000, 32'h0000_00FF, OFF_OUT,    32'hA5, 8'hA5, 8'h0F};
        vecs[4]  = '{OFF_IRQ_EN, 4'b0001, 32'h0000_003C, OFF_IRQ_EN, 32'h3C, 8'hA5, 8'h0F};
        vecs[5]  = '{OFF_RISE,   4'b0011, 32'h0000_11C3, OFF_RISE,   32'hC3, 8'hA5, 8'h0F};
        vecs[6]  = '{OFF_IN,     4'b0001, 32'h0000_00FF, OFF_IN,     32'h00, 8'hA5, 8'h0F};
        vecs[7]  = '{3'd7,       4'b1111, 32'hFFFF_FFFF, 3'd7,       32'h00, 8'hA5, 8'h0F};
        vecs[8]  = '{OFF_TOGGLE, 4'b0001, 32'h0000_00FF, OFF_TOGGLE, 32'h00, OUT_AFTER_TGL, 8'h0F};
        vecs[9]  = '{OFF_STATUS, 4'b0001, 32'h0000_00FF, OFF_STATUS, 32'h00, OUT_AFTER_TGL, 8'h0F};
        vecs[10] = '{OFF_OUT,    4'b0000, 32'h0000_0000, OFF_OUT,    32'(OUT_AFTER_TGL), OUT_AFTER_TGL, 8'h0F};

        rst = 1'b1; sel = 1'b0; addr = '0; wr = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0; wdata3 = '0; gpio_i = '0;
        tick();
        tick();
        check("reset gpio_o", 32'(gpio_o), 32'h0);
        check("reset gpio_oe", 32'(gpio_oe), 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        check("reset rdata", rdata, 32'h0);
        rst = 1'b0;
        repeat (S + 3) tick();

        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].waddr, vecs[i].strb, vecs[i].wdata);
            check($sformatf("vec%0d gpio_o", i), 32'(gpio_o), 32'(vecs[i].exp_o));
            check($sformatf("vec%0d gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            bus_read(vecs[i].raddr, d);
            check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
        end

        // Synchroniser latency: IN must step straight from 00 to 81, at the right edge.
        do_reset();
        repeat (S + 3) tick();
        drive_bus(1'b1, OFF_IN, 4'b0000, 32'h0);
        gpio_i = 8'h81;
        for (int k = 1; k <= S + 3; k++) begin
            tick();
            check($sformatf("in_sync edge%0d", k), rdata, (k >= S + 1) ? 32'h81 : 32'h0);
        end
        bus_idle();
        gpio_i = 8'h00;

        // Rising edge on pin 0 -> STATUS, then irq one edge later; W1C clears it.
        do_reset();
        bus_write(OFF_IRQ_EN, 4'b0001, 32'h01);
        bus_write(OFF_RISE, 4'b0001, 32'h01);
        repeat (S + 3) tick();
        gpio_i = 8'h01;
        for (int k = 1; k <= S + 2; k++) begin
            tick();
            check($sformatf("irq rise edge%0d", k), 32'(irq), (k >= S + 2) ? 32'h1 : 32'h0);
        end
        bus_read(OFF_STATUS, d);
        check("status after rise", d, 32'h01);
        bus_write(OFF_STATUS, 4'b0001, 32'h01);
        check("irq at w1c edge", 32'(irq), 32'h1);
        tick();
        check("irq after w1c", 32'(irq), 32'h0);
        bus_read(OFF_STATUS, d);
        check("status after w1c", d, 32'h00);

        // Set beats clear: re-arm STATUS[0], then land a W1C on the cycle of a new edge.
        gpio_i = 8'h00;
        repeat (S + 2) tick();
        gpio_i = 8'h01;
        repeat (S + 3) tick();
        check("irq rearmed", 32'(irq), 32'h1);
        gpio_i = 8'h00;
        repeat (S + 2) tick();
        check("no falling edge irq", 32'(irq), 32'h1);
        gpio_i = 8'h01;
        repeat (S) tick();
        bus_write(OFF_STATUS, 4'b0001, 32'h01);
        tick();
        check("set beats clear irq", 32'(irq), 32'h1);
        bus_read(OFF_STATUS, d);
        check("set beats clear status", d, 32'h01);

        // Asynchronous reset mid-cycle with live state.
        bus_write(OFF_OUT, 4'b0001, 32'hA5);
        bus_write(OFF_DIR, 4'b0001, 32'hFF);
        bus_read(OFF_OUT, d);
        check("pre-reset rdata", d, 32'hA5);
        check("pre-reset gpio_o", 32'(gpio_o), 32'hA5);
        #2;
        rst = 1'b1;
        #1;
        check("async rst gpio_o", 32'(gpio_o), 32'h0);
        check("async rst gpio_oe", 32'(gpio_oe), 32'h0);
        check("async rst irq", 32'(irq), 32'h0);
        check("async rst rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;

        // Pins high across reset release must not look like rising edges.
        gpio_i = 8'hFF;
        do_reset();
        bus_write(OFF_RISE, 4'b0001, 32'hFF);
        bus_write(OFF_IRQ_EN, 4'b0001, 32'hFF);
        repeat (S + 3) tick();
        bus_read(OFF_STATUS, d);
        check("warmup status", d, 32'h00);
        check("warmup irq", 32'(irq), 32'h0);

        bus_write(OFF_OUT, 4'b0001, 32'hF0);
        bus_write(OFF_TOGGLE, 4'b0001, 32'hFF);
`ifdef GPIO_TOGGLE_EN
        check("toggle gpio_o", 32'(gpio_o), 32'h0F);
`else
        check("reserved toggle gpio_o", 32'(gpio_o), 32'hF0);
`endif

        // Randomized traffic against the reference model.
        gpio_i = '0;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) gpio_i = W'($urandom);
            if (op == 0) bus_idle();
            else drive_bus(1'b1, 3'($urandom_range(0, 7)), (op == 1) ? 4'($urandom) : 4'b0000, $urandom);
            model_step();
            tick();
            check($sformatf("rnd gpio_o c%0d", c), 32'(gpio_o), 32'(m_out));
            check($sformatf("rnd gpio_oe c%0d", c), 32'(gpio_oe), 32'(m_dir));
            check($sformatf("rnd irq c%0d", c), 32'(irq), 32'(m_irq));
            check($sformatf("rnd rdata c%0d", c), rdata, m_rdata);
        end
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
